// File: rtl/fcmp_pipe.sv
// Two-stage pipelined IEEE-754 compare / min / max unit for generic binary formats.
// Valid/ready stream with backpressure, NaN-aware relations and a sticky invalid flag.
module fcmp_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic [EXP_W+MAN_W:0]     in_a,
    input  logic [EXP_W+MAN_W:0]     in_b,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_result,
    output logic                     out_altb,
    output logic                     out_blta,
    output logic                     out_aeqb,
    output logic                     out_unord,
    output logic                     out_invalid,
    output logic [TAG_W-1:0]         out_tag,
    input  logic                     clr_flags,
    output logic                     flag_invalid
);

    localparam int W = 1 + EXP_W + MAN_W;

    localparam logic [2:0] OP_EQ    = 3'd0;
    localparam logic [2:0] OP_LT    = 3'd1;
    localparam logic [2:0] OP_LE    = 3'd2;
    localparam logic [2:0] OP_MIN   = 3'd3;
    localparam logic [2:0] OP_MAX   = 3'd4;
    localparam logic [2:0] OP_UNORD = 3'd5;

    localparam logic [W-1:0] CANON_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic zero;
        logic inf;
        logic qnan;
        logic snan;
        logic sign;
    } cls_t;

    function automatic cls_t classify(input logic [W-1:0] x);
        cls_t c;
        logic exp_ones;
        logic exp_zero;
        logic frac_zero;
        exp_ones  = &x[W-2:MAN_W];
        exp_zero  = ~|x[W-2:MAN_W];
        frac_zero = ~|x[MAN_W-1:0];
        c.zero = exp_zero & frac_zero;
        c.inf  = exp_ones & frac_zero;
        c.qnan = exp_ones & ~frac_zero & x[MAN_W-1];
        c.snan = exp_ones & ~frac_zero & ~x[MAN_W-1];
        c.sign = x[W-1];
        return c;
    endfunction

    logic             ready_en;
    logic             s1_valid;
    logic             s2_valid;
    logic             s1_adv;
    logic             s2_adv;

    logic [2:0]       op_p1;
    logic [TAG_W-1:0] tag_p1;
    logic [W-1:0]     a_p1;
    logic [W-1:0]     b_p1;
    cls_t             cls_a_p1;
    cls_t             cls_b_p1;
    logic             mag_lt_p1;
    logic             mag_eq_p1;

    logic [W-1:0]     result_p2;
    logic             altb_p2;
    logic             blta_p2;
    logic             aeqb_p2;
    logic             unord_p2;
    logic             inv_p2;
    logic [TAG_W-1:0] tag_p2;
    logic             flag_q;

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = ready_en && s1_adv;

    // Infinity needs no special casing: its encoding already orders correctly by magnitude.
    logic unused_inf;
    assign unused_inf = cls_a_p1.inf ^ cls_b_p1.inf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en <= 1'b0;
            s1_valid <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (s1_adv)
                s1_valid <= in_valid && in_ready;
        end
    end

    // ---- stage 1: operand classification and {exp,frac} magnitude compare ----
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            op_p1     <= in_op;
            tag_p1    <= in_tag;
            a_p1      <= in_a;
            b_p1      <= in_b;
            cls_a_p1  <= classify(in_a);
            cls_b_p1  <= classify(in_b);
            mag_lt_p1 <= in_a[W-2:0] <  in_b[W-2:0];
            mag_eq_p1 <= in_a[W-2:0] == in_b[W-2:0];
        end
    end

    logic         nan_a;
    logic         nan_b;
    logic         any_nan;
    logic         any_snan;
    logic         both_zero;
    logic         rel_lt;
    logic         rel_gt;
    logic         rel_eq;
    logic         rel_un;
    logic [W-1:0] res_c;
    logic         inv_c;

    always_comb begin
        nan_a     = cls_a_p1.qnan | cls_a_p1.snan;
        nan_b     = cls_b_p1.qnan | cls_b_p1.snan;
        any_nan   = nan_a | nan_b;
        any_snan  = cls_a_p1.snan | cls_b_p1.snan;
        both_zero = cls_a_p1.zero & cls_b_p1.zero;

        rel_lt = 1'b0;
        rel_gt = 1'b0;
        rel_eq = 1'b0;
        rel_un = 1'b0;
        if (any_nan) begin
            rel_un = 1'b1;
        end else if (both_zero) begin
            rel_eq = 1'b1;
        end else if (cls_a_p1.sign != cls_b_p1.sign) begin
            rel_lt = cls_a_p1.sign;
            rel_gt = cls_b_p1.sign;
        end else if (mag_eq_p1) begin
            rel_eq = 1'b1;
        end else begin
            // Both negative: larger magnitude is the smaller value.
            rel_lt = mag_lt_p1 ^ cls_a_p1.sign;
            rel_gt = ~(mag_lt_p1 ^ cls_a_p1.sign);
        end

        res_c = '0;
        inv_c = 1'b0;
        case (op_p1)
            OP_EQ: begin
                res_c[0] = rel_eq;
                inv_c    = any_snan;
            end
            OP_LT: begin
                res_c[0] = rel_lt;
                inv_c    = any_nan;
            end
            OP_LE: begin
                res_c[0] = rel_lt | rel_eq;
                inv_c    = any_nan;
            end
            OP_UNORD: begin
                res_c[0] = rel_un;
                inv_c    = any_snan;
            end
            OP_MIN, OP_MAX: begin
                inv_c = any_snan;
                if (nan_a && nan_b)
                    res_c = CANON_QNAN;
                else if (nan_a)
                    res_c = b_p1;
                else if (nan_b)
                    res_c = a_p1;
                else if (op_p1 == OP_MIN)
                    res_c = (both_zero ? (cls_a_p1.sign | ~cls_b_p1.sign) : ~rel_gt) ? a_p1 : b_p1;
                else
                    res_c = (both_zero ? (~cls_a_p1.sign | cls_b_p1.sign) : ~rel_lt) ? a_p1 : b_p1;
            end
            default: begin
                inv_c  = 1'b1;
                rel_lt = 1'b0;
                rel_gt = 1'b0;
                rel_eq = 1'b0;
                rel_un = 1'b0;
            end
        endcase
    end

    // ---- stage 2: final result, relation flags and sticky invalid ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            result_p2 <= '0;
            altb_p2   <= 1'b0;
            blta_p2   <= 1'b0;
            aeqb_p2   <= 1'b0;
            unord_p2  <= 1'b0;
            inv_p2    <= 1'b0;
            tag_p2    <= '0;
            flag_q    <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    result_p2 <= res_c;
                    altb_p2   <= rel_lt;
                    blta_p2   <= rel_gt;
                    aeqb_p2   <= rel_eq;
                    unord_p2  <= rel_un;
                    inv_p2    <= inv_c;
                    tag_p2    <= tag_p1;
                end
            end
            if (s2_valid && out_ready && inv_p2)
                flag_q <= 1'b1;
            else if (clr_flags)
                flag_q <= 1'b0;
        end
    end

    assign out_valid    = s2_valid;
    assign out_result   = result_p2;
    assign out_altb     = altb_p2;
    assign out_blta     = blta_p2;
    assign out_aeqb     = aeqb_p2;
    assign out_unord    = unord_p2;
    assign out_invalid  = inv_p2;
    assign out_tag      = tag_p2;
    assign flag_invalid = flag_q;

endmodule

// File: tb/tb_fcmp_pipe.sv
// Bench for fcmp_pipe (binary32): directed scenarios plus randomized traffic
// scored against a value-ordering reference model.
module tb_fcmp_pipe;

    localparam logic [2:0] EQ = 3'd0, LT = 3'd1, LE = 3'd2, MN = 3'd3, MX = 3'd4, UN = 3'd5;

    logic        clk, rst, in_valid, in_ready, out_valid, out_ready, clr_flags, flag_invalid;
    logic [2:0]  in_op;
    logic [31:0] in_a, in_b, out_result;
    logic [3:0]  in_tag, out_tag;
    logic        out_altb, out_blta, out_aeqb, out_unord, out_invalid;

    typedef struct packed {
        logic [31:0] res;
        logic        altb, blta, aeqb, unord, inv;
        logic [3:0]  tag;
    } rec_t;

    rec_t exp_q[$];
    rec_t got_q[$];
    int   checks = 0;
    int   passes = 0;
    bit   stop_tog;

    fcmp_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_altb(out_altb), .out_blta(out_blta), .out_aeqb(out_aeqb),
        .out_unord(out_unord), .out_invalid(out_invalid), .out_tag(out_tag),
        .clr_flags(clr_flags), .flag_invalid(flag_invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: order non-NaN values by a signed integer key (sign-magnitude -> two's complement).
    function automatic rec_t ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic [3:0] tag);
        rec_t r;
        logic na, nb, sa, sb, un, lt, gt, eq;
        longint ka, kb;
        na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        sa = na && !a[22];
        sb = nb && !b[22];
        ka = longint'(a[30:0]); if (a[31]) ka = -ka;
        kb = longint'(b[30:0]); if (b[31]) kb = -kb;
        un = na || nb;
        lt = !un && (ka < kb);
        gt = !un && (ka > kb);
        eq = !un && (ka == kb);
        r = '0;
        r.tag = tag;
        r.altb = lt; r.blta = gt; r.aeqb = eq; r.unord = un;
        case (op)
            EQ: begin r.res = {31'b0, eq}; r.inv = sa || sb; end
            LT: begin r.res = {31'b0, lt}; r.inv = un; end
            LE: begin r.res = {31'b0, lt || eq}; r.inv = un; end
            UN: begin r.res = {31'b0, un}; r.inv = sa || sb; end
            MN, MX: begin
                r.inv = sa || sb;
                if (na && nb)            r.res = 32'h7FC00000;
                else if (na)             r.res = b;
                else if (nb)             r.res = a;
                else if (eq && a != b)   r.res = (op == MN) ? 32'h80000000 : 32'h00000000;
                else if (op == MN)       r.res = gt ? b : a;
                else                     r.res = lt ? b : a;
            end
            default: begin
                r.res = '0; r.inv = 1'b1;
                r.altb = 0; r.blta = 0; r.aeqb = 0; r.unord = 0;
            end
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) exp_q.push_back(ref_op(in_op, in_a, in_b, in_tag));
            if (out_valid && out_ready)
                got_q.push_back(rec_t'({out_result, out_altb, out_blta, out_aeqb, out_unord, out_invalid, out_tag}));
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        int n = 0;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
        @(negedge clk);
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) begin
            checks++;
            $display("FAIL send_timeout in_ready=%b required=1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int k = 0;
        while (got_q.size() < n && k < 200) begin @(negedge clk); k++; end
        #1;
    endtask

    function automatic logic [31:0] rnd_fp();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: return {r[31], 31'h0};
            1: return {r[31], 8'hFF, 23'h0};
            2: return {r[31], 8'hFF, 1'b1, r[21:0]};
            3: return {r[31], 8'hFF, 1'b0, r[21:1], 1'b1};
            4: return {r[31], 8'h00, r[22:0]};
            default: return r;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 0; in_op = 0; in_a = 0; in_b = 0; in_tag = 0;
        out_ready = 1'b1; clr_flags = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, in_ready, flag_invalid, out_result, out_altb, out_blta, out_aeqb, out_unord, out_invalid, out_tag} !== '0)
            $display("FAIL reset_outputs valid=%b ready=%b flag=%b result=%h required all zero", out_valid, in_ready, flag_invalid, out_result);
        else passes++;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) $display("FAIL reset_release ready=%b valid=%b required 1/0", in_ready, out_valid);
        else passes++;
    endtask

    task automatic test_lt_basic();
        rec_t g, e;
        send(LT, 32'hBF800000, 32'h3F800000, 4'd1);
        send(LT, 32'h3F800000, 32'hBF800000, 4'd2);
        wait_results(2);
        checks++;
        if (got_q.size() < 2) begin $display("FAIL lt_count got=%0d required=2", got_q.size()); got_q.delete(); exp_q.delete(); return; end
        passes++;
        g = got_q.pop_front(); e = exp_q.pop_front();
        checks++; if (g !== e) $display("FAIL lt_model got=%h required=%h", g, e); else passes++;
        checks++;
        if ({g.res, g.altb, g.blta, g.inv, g.tag} !== {32'h1, 1'b1, 1'b0, 1'b0, 4'd1})
            $display("FAIL lt_neg_pos result=%h altb=%b inv=%b required 1/1/0", g.res, g.altb, g.inv);
        else passes++;
        g = got_q.pop_front(); e = exp_q.pop_front();
        checks++; if (g !== e) $display("FAIL lt_model2 got=%h required=%h", g, e); else passes++;
        checks++;
        if ({g.res, g.altb, g.blta, g.tag} !== {32'h0, 1'b0, 1'b1, 4'd2})
            $display("FAIL lt_pos_neg result=%h blta=%b required 0/1", g.res, g.blta);
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_sign();
        rec_t g, e;
        logic [31:0] want [5] = '{32'h1, 32'h80000000, 32'h0, 32'h80000000, 32'h0};
        send(EQ, 32'h80000000, 32'h00000000, 4'd3);
        send(MN, 32'h80000000, 32'h00000000, 4'd4);
        send(MX, 32'h80000000, 32'h00000000, 4'd5);
        send(MN, 32'h00000000, 32'h80000000, 4'd6);
        send(MX, 32'h00000000, 32'h80000000, 4'd7);
        wait_results(5);
        checks++;
        if (got_q.size() < 5) begin $display("FAIL zero_count got=%0d required=5", got_q.size()); got_q.delete(); exp_q.delete(); return; end
        passes++;
        for (int i = 0; i < 5; i++) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) $display("FAIL zero_model[%0d] got=%h required=%h", i, g, e); else passes++;
            checks++;
            if ({g.res, g.aeqb} !== {want[i], 1'b1}) $display("FAIL zero_sign[%0d] result=%h aeqb=%b required %h/1", i, g.res, g.aeqb, want[i]);
            else passes++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_nan();
        rec_t g, e;
        send(EQ, 32'h7FC00000, 32'h3F800000, 4'd8);
        send(LT, 32'h7FC00000, 32'h3F800000, 4'd9);
        send(MN, 32'h7F800001, 32'h40000000, 4'd10);
        send(MN, 32'h7FC00000, 32'hFF800005, 4'd11);
        wait_results(4);
        checks++;
        if (got_q.size() < 4) begin $display("FAIL nan_count got=%0d required=4", got_q.size()); got_q.delete(); exp_q.delete(); return; end
        passes++;
        for (int i = 0; i < 4; i++) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) $display("FAIL nan_model[%0d] got=%h required=%h", i, g, e); else passes++;
            checks++;
            case (i)
                0: if ({g.res, g.unord, g.inv} !== {32'h0, 1'b1, 1'b0}) $display("FAIL nan_eq result=%h unord=%b inv=%b required 0/1/0", g.res, g.unord, g.inv); else passes++;
                1: if ({g.res, g.unord, g.inv} !== {32'h0, 1'b1, 1'b1}) $display("FAIL nan_lt result=%h unord=%b inv=%b required 0/1/1", g.res, g.unord, g.inv); else passes++;
                2: if ({g.res, g.inv} !== {32'h40000000, 1'b1}) $display("FAIL nan_min_snan result=%h inv=%b required 40000000/1", g.res, g.inv); else passes++;
                default: if (g.res !== 32'h7FC00000) $display("FAIL nan_min_both result=%h required=7fc00000", g.res); else passes++;
            endcase
        end
        @(posedge clk); #1;
        checks++; if (flag_invalid !== 1'b1) $display("FAIL nan_flag flag=%b required=1", flag_invalid); else passes++;
    endtask

    task automatic test_reset_midstream();
        rec_t g, e;
        int acc_wait;
        send(LE, 32'h3F800000, 32'h40000000, 4'd1);
        send(LE, 32'h40000000, 32'h3F800000, 4'd2);
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, flag_invalid} !== 2'b00) $display("FAIL midreset valid=%b flag=%b required 0/0", out_valid, flag_invalid);
        else passes++;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete(); got_q.delete();
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL midreset_ready ready=%b required=1", in_ready); else passes++;
        send(LE, 32'h40400000, 32'h40400000, 4'd12);
        checks++; if (out_valid !== 1'b0) $display("FAIL latency_early valid=%b required=0", out_valid); else passes++;
        @(posedge clk); #1;
        acc_wait = 0;
        checks++; if (out_valid !== 1'b1) $display("FAIL latency_two valid=%b required=1", out_valid); else passes++;
        wait_results(1);
        checks++;
        if (got_q.size() < 1) begin $display("FAIL midreset_count got=%0d required=1", got_q.size()); got_q.delete(); exp_q.delete(); return; end
        passes++;
        g = got_q.pop_front(); e = exp_q.pop_front();
        checks++;
        if (g !== e || g.res !== 32'h1 || g.tag !== 4'd12) $display("FAIL midreset_result got=%h required=%h", g, e);
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        rec_t g, e;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(LT, rnd_fp(), rnd_fp(), 4'(i));
            end
        join_none
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if ({exp_q.size() == 2, in_ready, out_valid, out_tag} !== {1'b1, 1'b0, 1'b1, 4'd0})
            $display("FAIL bp_stall accepted=%0d ready=%b valid=%b tag=%0d required 2/0/1/0", exp_q.size(), in_ready, out_valid, out_tag);
        else passes++;
        out_ready = 1'b1;
        wait_results(4);
        checks++;
        if (got_q.size() < 4) begin $display("FAIL bp_count got=%0d required=4", got_q.size()); got_q.delete(); exp_q.delete(); return; end
        passes++;
        for (int i = 0; i < 4; i++) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e || g.tag !== 4'(i)) $display("FAIL bp_order[%0d] got=%h required=%h", i, g, e);
            else passes++;
        end
        repeat (4) @(posedge clk);
        #1;
        checks++; if (got_q.size() != 0) $display("FAIL bp_dup extra=%0d required=0", got_q.size()); else passes++;
    endtask

    task automatic test_subnormal_flags();
        rec_t g, e;
        int n;
        send(LT, 32'h00000001, 32'h00800000, 4'd5);
        send(LT, 32'hFF800000, 32'hFF7FFFFF, 4'd6);
        send(LT, 32'h7FC00000, 32'h3F800000, 4'd7);
        wait_results(3);
        checks++;
        if (got_q.size() < 3) begin $display("FAIL sub_count got=%0d required=3", got_q.size()); got_q.delete(); exp_q.delete(); return; end
        passes++;
        for (int i = 0; i < 3; i++) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) $display("FAIL sub_model[%0d] got=%h required=%h", i, g, e); else passes++;
            if (i < 2) begin
                checks++;
                if ({g.res, g.altb} !== {32'h1, 1'b1}) $display("FAIL sub_inf_lt[%0d] result=%h altb=%b required 1/1", i, g.res, g.altb);
                else passes++;
            end
        end
        @(posedge clk); #1;
        checks++; if (flag_invalid !== 1'b1) $display("FAIL flag_set flag=%b required=1", flag_invalid); else passes++;
        clr_flags = 1'b1;
        @(posedge clk); #1;
        clr_flags = 1'b0;
        checks++; if (flag_invalid !== 1'b0) $display("FAIL flag_clear flag=%b required=0", flag_invalid); else passes++;
        out_ready = 1'b0;
        send(LE, 32'h7FC00000, 32'h00000000, 4'd9);
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        clr_flags = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (flag_invalid !== 1'b1) $display("FAIL flag_set_wins flag=%b required=1", flag_invalid); else passes++;
        @(posedge clk); #1;
        clr_flags = 1'b0;
        checks++; if (flag_invalid !== 1'b0) $display("FAIL flag_clear2 flag=%b required=0", flag_invalid); else passes++;
        checks++;
        if (got_q.size() < 1) begin $display("FAIL setwins_count got=%0d required=1", got_q.size()); got_q.delete(); exp_q.delete(); return; end
        passes++;
        g = got_q.pop_front(); e = exp_q.pop_front();
        checks++; if (g !== e) $display("FAIL setwins_model got=%h required=%h", g, e); else passes++;
    endtask

    task automatic test_random();
        rec_t g, e;
        logic [31:0] a, b;
        logic exp_flag = 1'b0;
        int errs = 0;
        stop_tog = 1'b0;
        fork
            begin
                while (!stop_tog) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int i = 0; i < 300; i++) begin
            a = rnd_fp();
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = {~a[31], a[30:0]};
                default: b = rnd_fp();
            endcase
            send(3'($urandom_range(0, 7)), a, b, 4'(i));
            if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
        end
        stop_tog = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b1;
        wait_results(300);
        checks++;
        if (got_q.size() < 300) begin $display("FAIL rand_count got=%0d required=300", got_q.size()); got_q.delete(); exp_q.delete(); return; end
        passes++;
        for (int i = 0; i < 300; i++) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            exp_flag |= e.inv;
            checks++;
            if (g !== e) begin
                if (errs < 10) $display("FAIL rand[%0d] got=%h required=%h", i, g, e);
                errs++;
            end else passes++;
        end
        @(posedge clk); #1;
        checks++; if (flag_invalid !== exp_flag) $display("FAIL rand_flag flag=%b required=%b", flag_invalid, exp_flag); else passes++;
    endtask

    initial begin
        test_reset();
        test_lt_basic();
        test_zero_sign();
        test_nan();
        test_reset_midstream();
        test_backpressure();
        test_subnormal_flags();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
